// File: rtl/swan_core_arbiter.sv
// Round-robin arbiter and job sequencer sharing one serial SWAN core between
// two requesters. A job is accepted, launched with a one-cycle start pulse,
// supervised by a watchdog while the core runs, and its result is returned on
// a backpressured response channel.
module swan_core_arbiter #(
    parameter int BLOCK_SIZE = 128,
    parameter int KEY_SIZE   = 128,
    parameter int TIMEOUT    = 1023,
    parameter int CNT_W      = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req0_valid,
    output logic                  req0_ready,
    input  logic [0:KEY_SIZE-1]   req0_key,
    input  logic [0:BLOCK_SIZE-1] req0_inp,
    input  logic                  req1_valid,
    output logic                  req1_ready,
    input  logic [0:KEY_SIZE-1]   req1_key,
    input  logic [0:BLOCK_SIZE-1] req1_inp,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic                  rsp_id,
    output logic                  rsp_err,
    output logic [0:BLOCK_SIZE-1] rsp_data,
    output logic                  core_start,
    output logic [0:KEY_SIZE-1]   core_key,
    output logic [0:BLOCK_SIZE-1] core_inp,
    input  logic                  core_ready,
    input  logic [0:BLOCK_SIZE-1] core_out
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LAUNCH,
        S_BUSY,
        S_RESP
    } state_t;

    localparam logic [CNT_W-1:0] TO_CNT = CNT_W'(TIMEOUT);

    state_t                state_q, state_d;
    logic                  rr_q, rr_d;      // index of the requester granted last
    logic [CNT_W-1:0]      cnt_q, cnt_d;    // watchdog: cycles spent in BUSY
    logic [0:KEY_SIZE-1]   key_q, key_d;
    logic [0:BLOCK_SIZE-1] inp_q, inp_d;
    logic                  id_q, id_d;
    logic                  err_q, err_d;
    logic [0:BLOCK_SIZE-1] data_q, data_d;

    logic gnt0;
    logic gnt1;

    // On a tie the requester that was not granted last wins.
    assign gnt0 = req0_valid & (~req1_valid | rr_q);
    assign gnt1 = req1_valid & (~req0_valid | ~rr_q);

    assign rsp_valid  = (state_q == S_RESP);
    assign core_start = (state_q == S_LAUNCH);
    assign rsp_id     = id_q;
    assign rsp_err    = err_q;
    assign rsp_data   = data_q;
    assign core_key   = key_q;
    assign core_inp   = inp_q;

    // Next-state, handshake and datapath-capture logic.
    always_comb begin
        state_d    = state_q;
        rr_d       = rr_q;
        cnt_d      = cnt_q;
        key_d      = key_q;
        inp_d      = inp_q;
        id_d       = id_q;
        err_d      = err_q;
        data_d     = data_q;
        req0_ready = 1'b0;
        req1_ready = 1'b0;

        case (state_q)
            S_IDLE: begin
                // Readys are combinational, so they are masked by the reset
                // input to keep every output low while reset is held.
                req0_ready = gnt0 & rst;
                req1_ready = gnt1 & rst;
                if (gnt0) begin
                    key_d   = req0_key;
                    inp_d   = req0_inp;
                    id_d    = 1'b0;
                    rr_d    = 1'b0;
                    state_d = S_LAUNCH;
                end else if (gnt1) begin
                    key_d   = req1_key;
                    inp_d   = req1_inp;
                    id_d    = 1'b1;
                    rr_d    = 1'b1;
                    state_d = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                cnt_d   = '0;
                state_d = S_BUSY;
            end
            S_BUSY: begin
                cnt_d = cnt_q + 1'b1;
                // A completion strobe takes priority over a coincident timeout.
                if (core_ready) begin
                    data_d  = core_out;
                    err_d   = 1'b0;
                    state_d = S_RESP;
                end else if (cnt_q == TO_CNT) begin
                    data_d  = '0;
                    err_d   = 1'b1;
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State, pointer, watchdog and job/response registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            rr_q    <= 1'b1;
            cnt_q   <= '0;
            key_q   <= '0;
            inp_q   <= '0;
            id_q    <= 1'b0;
            err_q   <= 1'b0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            cnt_q   <= cnt_d;
            key_q   <= key_d;
            inp_q   <= inp_d;
            id_q    <= id_d;
            err_q   <= err_d;
            data_q  <= data_d;
        end
    end

endmodule

// File: tb/tb_swan_core_arbiter.sv
// Directed bench for swan_core_arbiter with a known-answer core model.
module tb_swan_core_arbiter;

    logic         clk;
    logic         rst;
    logic         req0_valid, req0_ready;
    logic [0:127] req0_key, req0_inp;
    logic         req1_valid, req1_ready;
    logic [0:127] req1_key, req1_inp;
    logic         rsp_valid, rsp_ready, rsp_id, rsp_err;
    logic [0:127] rsp_data;
    logic         core_start;
    logic [0:127] core_key, core_inp;
    logic         core_ready;
    logic [0:127] core_out;

    int checks = 0;
    int errors = 0;

    localparam logic [0:127] K1 = 128'hffffffffffffffffffffffffffffffff;
    localparam logic [0:127] P1 = 128'hf0debc9a78563412f0debc9a78563412;
    localparam logic [0:127] C1 = 128'h8b9d520a184f4dc8189263a70c0eebba;
    localparam logic [0:127] K2 = 128'h0;
    localparam logic [0:127] P2 = 128'h78563412785634127856341278563412;
    localparam logic [0:127] C2 = 128'h7471e75b14c448bbafc68d66170d1ac9;
    localparam logic [0:127] K3 = 128'h78563412785634127856341278563412;
    localparam logic [0:127] P3 = 128'h11111111111111111111111111111111;
    localparam logic [0:127] C3 = 128'hfaf0220b1ac0c6ce55a98207d26e67ec;

    swan_core_arbiter #(
        .BLOCK_SIZE(128),
        .KEY_SIZE  (128),
        .TIMEOUT   (15),
        .CNT_W     (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_key   (req0_key),
        .req0_inp   (req0_inp),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_key   (req1_key),
        .req1_inp   (req1_inp),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_err    (rsp_err),
        .rsp_data   (rsp_data),
        .core_start (core_start),
        .core_key   (core_key),
        .core_inp   (core_inp),
        .core_ready (core_ready),
        .core_out   (core_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Known-answer table for the cipher; other inputs map to a fixed mixing
    // function so arbitrary jobs still have a predictable result.
    function automatic logic [0:127] core_model(input logic [0:127] k, input logic [0:127] b);
        if (k == K1 && b == P1) return C1;
        if (k == K2 && b == P2) return C2;
        if (k == K3 && b == P3) return C3;
        return b ^ {k[64:127], k[0:63]} ^ 128'h0123456789abcdeffedcba9876543210;
    endfunction

    task automatic tick;
        @(negedge clk);
    endtask

    // Called in the LAUNCH cycle: strobes core_ready lat cycles later for one cycle.
    task automatic drive_core(input int lat);
        repeat (lat) tick;
        core_ready = 1'b1;
        core_out   = core_model(core_key, core_inp);
        tick;
        core_ready = 1'b0;
        core_out   = '0;
    endtask

    task automatic test_reset;
        rst = 1'b0;
        req0_valid = 1'b1; req0_key = K1; req0_inp = P1;
        #2;
        checks++; if (rsp_valid !== 1'b0 || core_start !== 1'b0) begin errors++;
            $display("FAIL reset_ctrl: got valid=%b start=%b, expected 0 0", rsp_valid, core_start); end
        checks++; if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin errors++;
            $display("FAIL reset_ready: got %b%b, expected 00", req0_ready, req1_ready); end
        checks++; if (core_key !== '0 || core_inp !== '0 || rsp_data !== '0 || {rsp_id, rsp_err} !== 2'b00) begin errors++;
            $display("FAIL reset_data: got key=%h inp=%h data=%h, expected zeros", core_key, core_inp, rsp_data); end
        req0_valid = 1'b0;
        tick;
        rst = 1'b1;
        tick;
    endtask

    task automatic test_single;
        int starts;
        req0_valid = 1'b1; req0_key = K1; req0_inp = P1;
        #1;
        checks++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin errors++;
            $display("FAIL single_grant: got %b%b, expected 10", req0_ready, req1_ready); end
        tick;
        req0_valid = 1'b0;
        checks++; if (core_start !== 1'b1) begin errors++;
            $display("FAIL single_start: got %b, expected 1", core_start); end
        checks++; if (core_key !== K1 || core_inp !== P1) begin errors++;
            $display("FAIL single_core_in: got %h %h, expected %h %h", core_key, core_inp, K1, P1); end
        starts = 1;
        for (int i = 0; i < 3; i++) begin
            tick;
            if (core_start) starts++;
        end
        core_ready = 1'b1; core_out = core_model(core_key, core_inp);
        tick;
        core_ready = 1'b0; core_out = '0;
        if (core_start) starts++;
        checks++; if (starts != 1) begin errors++;
            $display("FAIL single_start_len: got %0d cycles, expected 1", starts); end
        checks++; if (rsp_valid !== 1'b1) begin errors++;
            $display("FAIL single_latency: got rsp_valid=%b, expected 1", rsp_valid); end
        checks++; if (rsp_id !== 1'b0 || rsp_err !== 1'b0) begin errors++;
            $display("FAIL single_id_err: got %b%b, expected 00", rsp_id, rsp_err); end
        checks++; if (rsp_data !== C1) begin errors++;
            $display("FAIL single_data: got %h, expected %h", rsp_data, C1); end
        tick;
        checks++; if (rsp_valid !== 1'b0) begin errors++;
            $display("FAIL single_release: got rsp_valid=%b, expected 0", rsp_valid); end
    endtask

    task automatic test_round_robin;
        rst = 1'b0;
        tick;
        rst = 1'b1;
        req0_valid = 1'b1; req0_key = K2; req0_inp = P2;
        req1_valid = 1'b1; req1_key = K3; req1_inp = P3;
        #1;
        checks++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin errors++;
            $display("FAIL rr_first_grant: got %b%b, expected 10", req0_ready, req1_ready); end
        tick;
        req0_valid = 1'b0;
        drive_core(2);
        checks++; if (rsp_valid !== 1'b1 || rsp_id !== 1'b0 || rsp_data !== C2) begin errors++;
            $display("FAIL rr_rsp0: got v=%b id=%b data=%h, expected 1 0 %h", rsp_valid, rsp_id, rsp_data, C2); end
        checks++; if (req1_ready !== 1'b0) begin errors++;
            $display("FAIL rr_hold1: got req1_ready=%b, expected 0", req1_ready); end
        tick;
        checks++; if (req1_ready !== 1'b1 || req0_ready !== 1'b0) begin errors++;
            $display("FAIL rr_second_grant: got %b%b, expected 01", req0_ready, req1_ready); end
        tick;
        req1_valid = 1'b0;
        drive_core(3);
        checks++; if (rsp_valid !== 1'b1 || rsp_id !== 1'b1 || rsp_err !== 1'b0 || rsp_data !== C3) begin errors++;
            $display("FAIL rr_rsp1: got v=%b id=%b err=%b data=%h, expected 1 1 0 %h", rsp_valid, rsp_id, rsp_err, rsp_data, C3); end
        tick;
    endtask

    task automatic test_backpressure;
        logic [0:127] k, b, exp;
        int bad_valid, bad_fields, bad_ready;
        k = 128'h0102030405060708090a0b0c0d0e0f10;
        b = 128'hdeadbeefcafef00d0123456789abcdef;
        exp = core_model(k, b);
        bad_valid = 0; bad_fields = 0; bad_ready = 0;
        rsp_ready = 1'b0;
        req0_valid = 1'b1; req0_key = k; req0_inp = b;
        tick;
        req0_valid = 1'b0;
        drive_core(2);
        req1_valid = 1'b1; req1_key = K3; req1_inp = P3;
        for (int i = 0; i < 20; i++) begin
            if (rsp_valid !== 1'b1) bad_valid++;
            if (rsp_id !== 1'b0 || rsp_err !== 1'b0 || rsp_data !== exp) bad_fields++;
            if (req0_ready !== 1'b0 || req1_ready !== 1'b0) bad_ready++;
            if (i == 5) begin core_ready = 1'b1; core_out = ~exp; end
            if (i == 6) begin core_ready = 1'b0; core_out = '0; end
            tick;
        end
        checks++; if (bad_valid != 0) begin errors++;
            $display("FAIL bp_valid: got %0d cycles without rsp_valid, expected 0", bad_valid); end
        checks++; if (bad_fields != 0) begin errors++;
            $display("FAIL bp_fields: got %0d unstable cycles, expected 0 (data %h vs %h)", bad_fields, rsp_data, exp); end
        checks++; if (bad_ready != 0) begin errors++;
            $display("FAIL bp_ready: got %0d cycles with a ready, expected 0", bad_ready); end
        rsp_ready = 1'b1;
        #1;
        checks++; if (rsp_valid !== 1'b1 || rsp_data !== exp) begin errors++;
            $display("FAIL bp_release: got v=%b data=%h, expected 1 %h", rsp_valid, rsp_data, exp); end
        tick;
        checks++; if (req1_ready !== 1'b1 || rsp_valid !== 1'b0) begin errors++;
            $display("FAIL bp_after: got req1_ready=%b rsp_valid=%b, expected 1 0", req1_ready, rsp_valid); end
        req1_valid = 1'b0;
    endtask

    task automatic test_watchdog;
        req0_valid = 1'b1; req0_key = K2; req0_inp = P1;
        tick;
        req0_valid = 1'b0;
        repeat (16) tick;
        checks++; if (rsp_valid !== 1'b0) begin errors++;
            $display("FAIL wd_early: got rsp_valid=%b at count 15, expected 0", rsp_valid); end
        tick;
        checks++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_data !== '0) begin errors++;
            $display("FAIL wd_abort: got v=%b err=%b data=%h, expected 1 1 0", rsp_valid, rsp_err, rsp_data); end
        tick;
        req0_valid = 1'b1; req0_key = K1; req0_inp = P1;
        tick;
        req0_valid = 1'b0;
        checks++; if (core_start !== 1'b1) begin errors++;
            $display("FAIL wd_relaunch: got core_start=%b, expected 1", core_start); end
        drive_core(5);
        checks++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_data !== C1) begin errors++;
            $display("FAIL wd_next_job: got v=%b err=%b data=%h, expected 1 0 %h", rsp_valid, rsp_err, rsp_data, C1); end
        tick;
    endtask

    task automatic test_race;
        req1_valid = 1'b1; req1_key = K3; req1_inp = P3;
        tick;
        req1_valid = 1'b0;
        drive_core(16);
        checks++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_data !== C3 || rsp_id !== 1'b1) begin errors++;
            $display("FAIL race_ready_wins: got v=%b id=%b err=%b data=%h, expected 1 1 0 %h", rsp_valid, rsp_id, rsp_err, rsp_data, C3); end
        tick;
    endtask

    task automatic test_stray;
        int bad;
        bad = 0;
        core_ready = 1'b1; core_out = C2;
        for (int i = 0; i < 3; i++) begin
            tick;
            if (rsp_valid !== 1'b0 || core_start !== 1'b0) bad++;
        end
        core_ready = 1'b0; core_out = '0;
        checks++; if (bad != 0) begin errors++;
            $display("FAIL stray_idle: got %0d cycles with activity, expected 0", bad); end
    endtask

    task automatic test_reset_busy;
        logic [0:127] b, exp;
        int bad;
        bad = 0;
        req0_valid = 1'b1; req0_key = K1; req0_inp = P1;
        tick;
        req0_valid = 1'b0;
        repeat (3) tick;
        req1_valid = 1'b1; req1_key = K2; req1_inp = 128'h00112233445566778899aabbccddeeff;
        #2;
        rst = 1'b0;
        #1;
        checks++; if (rsp_valid !== 1'b0 || core_start !== 1'b0 || req0_ready !== 1'b0 || req1_ready !== 1'b0) begin errors++;
            $display("FAIL rstb_ctrl: got v=%b start=%b rdy=%b%b, expected 0 0 00", rsp_valid, core_start, req0_ready, req1_ready); end
        checks++; if (core_key !== '0 || core_inp !== '0 || rsp_data !== '0) begin errors++;
            $display("FAIL rstb_data: got key=%h inp=%h data=%h, expected zeros", core_key, core_inp, rsp_data); end
        tick;
        rst = 1'b1;
        b = req1_inp;
        exp = core_model(K2, b);
        #1;
        checks++; if (req1_ready !== 1'b1) begin errors++;
            $display("FAIL rstb_grant: got req1_ready=%b, expected 1", req1_ready); end
        tick;
        req1_valid = 1'b0;
        checks++; if (core_start !== 1'b1) begin errors++;
            $display("FAIL rstb_launch: got core_start=%b, expected 1", core_start); end
        for (int i = 0; i < 3; i++) begin
            if (rsp_valid !== 1'b0) bad++;
            if (i < 2) tick;
        end
        core_ready = 1'b1; core_out = core_model(core_key, core_inp);
        tick;
        core_ready = 1'b0; core_out = '0;
        checks++; if (bad != 0) begin errors++;
            $display("FAIL rstb_no_stale: got %0d early responses, expected 0", bad); end
        checks++; if (rsp_valid !== 1'b1 || rsp_id !== 1'b1 || rsp_err !== 1'b0 || rsp_data !== exp) begin errors++;
            $display("FAIL rstb_job: got v=%b id=%b err=%b data=%h, expected 1 1 0 %h", rsp_valid, rsp_id, rsp_err, rsp_data, exp); end
        tick;
    endtask

    initial begin
        rst = 1'b0;
        req0_valid = 1'b0; req0_key = '0; req0_inp = '0;
        req1_valid = 1'b0; req1_key = '0; req1_inp = '0;
        rsp_ready = 1'b1;
        core_ready = 1'b0; core_out = '0;
        test_reset;
        test_single;
        test_round_robin;
        test_backpressure;
        test_watchdog;
        test_race;
        test_stray;
        test_reset_busy;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
